// File: rtl/fuzz_program_gen.sv
// fuzz_program_gen: seeded pseudo-random ISA program transmitter with expected mu-cost accounting
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, seed, length       begin a program (IDLE/DONE only); seed 0 maps to 1
//   busy, done                status: streaming / program complete
//   instr_valid, instr_ready  valid/ready link to the loader or fetch port
//   instr_data, instr_index   {opcode, a, b, TAG_BYTE} word and its 0-based index
//   exp_mu_discovery/_execution, exp_num_modules  costs of accepted words
module fuzz_program_gen #(
    parameter logic [31:0] LFSR_POLY   = 32'h80200003,
    parameter int          MAX_MODULES = 64,
    parameter logic [7:0]  TAG_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic [7:0]  length,
    output logic        busy,
    output logic        done,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [7:0]  instr_index,
    output logic [31:0] exp_mu_discovery,
    output logic [31:0] exp_mu_execution,
    output logic [6:0]  exp_num_modules
);
    typedef enum logic [1:0] {IDLE, GEN, HALT_EMIT, DONE} state_t;
    localparam logic [31:0] HALT_WORD = {8'hFF, 16'h0000, TAG_BYTE};
    state_t state, state_n;
    logic [31:0] lfsr, lfsr_step, seed_eff, exec_inc;
    logic [7:0] len, count, op;
    logic load, accept, last, pnew_ok;

    function automatic logic [31:0] word(input logic [31:0] l);
        logic [7:0] o;
        o = (l[2:1] == 2'd0) ? 8'h00 :
            (l[2:0] == 3'd4) ? 8'h0B :
            (l[2:0] == 3'd5) ? 8'h0C :
            (l[2:0] == 3'd6) ? 8'h0E : 8'h0A;
        return (o == 8'h00) ? {o, 2'b00, l[13:8], 8'h00, TAG_BYTE} : {o, l[15:8], l[23:16], TAG_BYTE};
    endfunction

    assign seed_eff  = (seed == 32'd0) ? 32'd1 : seed;
    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
    assign op        = instr_data[31:24];
    assign load      = start && (state == IDLE || state == DONE);
    assign accept    = instr_valid && instr_ready;
    // count < len whenever a GEN word is accepted, so count+1 cannot wrap here
    assign last      = (count + 8'd1) == len;
    // discovery is only charged while the module table still has room
    assign pnew_ok   = (op == 8'h00) && (exp_num_modules < 7'(MAX_MODULES));
    assign exec_inc  = (op == 8'h0A || op == 8'h0B) ? 32'd1 : (op == 8'h0C) ? 32'd3 : 32'd0;
    assign busy      = (state == GEN) || (state == HALT_EMIT);
    assign done      = (state == DONE);

    always_comb begin
        state_n = state;
        if (load)
            state_n = (length == 8'd0) ? HALT_EMIT : GEN;
        else if (accept && state == GEN && last)
            state_n = HALT_EMIT;
        else if (accept && state == HALT_EMIT)
            state_n = DONE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr             <= 32'd0;
            len              <= 8'd0;
            count            <= 8'd0;
            instr_valid      <= 1'b0;
            instr_data       <= 32'd0;
            instr_index      <= 8'd0;
            exp_mu_discovery <= 32'd0;
            exp_mu_execution <= 32'd0;
            exp_num_modules  <= 7'd0;
        end else if (load) begin
            lfsr             <= seed_eff;
            len              <= length;
            count            <= 8'd0;
            instr_valid      <= 1'b1;
            instr_data       <= (length == 8'd0) ? HALT_WORD : word(seed_eff);
            instr_index      <= 8'd0;
            exp_mu_discovery <= 32'd0;
            exp_mu_execution <= 32'd0;
            exp_num_modules  <= 7'd0;
        end else if (accept && state == GEN) begin
            lfsr             <= lfsr_step;
            count            <= count + 8'd1;
            instr_index      <= instr_index + 8'd1;
            instr_data       <= last ? HALT_WORD : word(lfsr_step);
            exp_mu_discovery <= exp_mu_discovery + {31'd0, pnew_ok};
            exp_num_modules  <= exp_num_modules + {6'd0, pnew_ok};
            exp_mu_execution <= exp_mu_execution + exec_inc;
        end else if (accept && state == HALT_EMIT) begin
            instr_valid      <= 1'b0;
            exp_mu_execution <= exp_mu_execution + 32'd1;
        end
    end
endmodule

// File: tb/tb_fuzz_program_gen.sv
// tb_fuzz_program_gen: self-checking bench for fuzz_program_gen against a program-level reference model
module tb_fuzz_program_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = 32'd0;
    logic [7:0]  length = 8'd0;
    logic        instr_ready = 1'b0;
    logic        busy, done, instr_valid;
    logic [31:0] instr_data, exp_mu_discovery, exp_mu_execution;
    logic [7:0]  instr_index;
    logic [6:0]  exp_num_modules;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mq[$];
    int m_disc, m_exec, m_mods;

    typedef struct {
        logic [31:0] seed;
        int          len;
        bit          rnd;
        bit          pulse;
        bit          fixed;
        int          disc;
        int          exec;
    } vec_t;
    vec_t vecs[7];

    fuzz_program_gen dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .length(length),
        .busy(busy), .done(done), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_index(instr_index),
        .exp_mu_discovery(exp_mu_discovery), .exp_mu_execution(exp_mu_execution),
        .exp_num_modules(exp_num_modules)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole program and its total costs, built straight from the ISA rules
    task automatic model(input logic [31:0] s, input int n);
        logic [31:0] l;
        int k;
        mq.delete();
        m_disc = 0;
        m_exec = 0;
        m_mods = 0;
        l = (s == 0) ? 32'd1 : s;
        for (int i = 0; i < n; i++) begin
            k = int'(l % 8);
            if (k < 2) begin
                mq.push_back({8'h00, 2'b00, l[13:8], 8'h00, 8'hA5});
                if (m_mods < 64) begin
                    m_disc++;
                    m_mods++;
                end
            end else begin
                case (k)
                    4: begin mq.push_back({8'h0B, l[15:8], l[23:16], 8'hA5}); m_exec += 1; end
                    5: begin mq.push_back({8'h0C, l[15:8], l[23:16], 8'hA5}); m_exec += 3; end
                    6: mq.push_back({8'h0E, l[15:8], l[23:16], 8'hA5});
                    default: begin mq.push_back({8'h0A, l[15:8], l[23:16], 8'hA5}); m_exec += 1; end
                endcase
            end
            l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        end
        mq.push_back(32'hFF0000A5);
        m_exec += 1;
    endtask

    task automatic run(input vec_t v);
        int got, cyc;
        model(v.seed, v.len);
        @(negedge clk);
        seed = v.seed;
        length = 8'(v.len);
        start = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_disc_clr", exp_mu_discovery, 0);
        chk("start_exec_clr", exp_mu_execution, 0);
        got = 0;
        cyc = 0;
        while (got < v.len + 1 && cyc < 3000) begin
            instr_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = v.pulse && (cyc == 2);
            if (start) begin
                seed = ~v.seed;
                length = 8'd9;
            end
            if (instr_valid && instr_ready) begin
                chk("word", instr_data, mq[got]);
                chk("index", instr_index, got);
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("word_count", got, v.len + 1);
        if (!v.rnd) chk("throughput_cycles", cyc, v.len + 1);
        chk("end_valid", instr_valid, 0);
        chk("end_busy", busy, 0);
        chk("end_done", done, 1);
        chk("end_disc", exp_mu_discovery, m_disc);
        chk("end_exec", exp_mu_execution, m_exec);
        chk("end_mods", exp_num_modules, m_mods);
        chk("mods_le_max", exp_num_modules <= 7'd64, 1);
        if (v.fixed) begin
            chk("fixed_disc", exp_mu_discovery, v.disc);
            chk("fixed_exec", exp_mu_execution, v.exec);
        end
    endtask

    initial begin
        vecs[0] = '{32'd0, 2, 1'b0, 1'b0, 1'b1, 1, 2};
        vecs[1] = '{32'h1234_5678, 0, 1'b0, 1'b0, 1'b1, 0, 1};
        vecs[2] = '{$urandom, 7, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[3] = '{$urandom, 12, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[4] = '{$urandom, 255, 1'b1, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{$urandom, 255, 1'b0, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{32'd0, 2, 1'b0, 1'b0, 1'b1, 1, 2};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", instr_data, 0);
        chk("rst_index", instr_index, 0);
        chk("rst_disc", exp_mu_discovery, 0);
        chk("rst_exec", exp_mu_execution, 0);
        chk("rst_mods", exp_num_modules, 0);
        rst = 1'b0;

        foreach (vecs[i]) run(vecs[i]);

        // back-pressure: first word and index held while ready is low
        @(negedge clk);
        seed = 32'd0;
        length = 8'd2;
        start = 1'b1;
        instr_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", instr_valid, 1);
            chk("stall_word", instr_data, 32'h000000A5);
            chk("stall_index", instr_index, 0);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        chk("stall_w0", instr_data, 32'h000000A5);
        @(negedge clk);
        chk("stall_w1", instr_data, 32'h0A0020A5);
        chk("stall_i1", instr_index, 1);
        @(negedge clk);
        chk("stall_w2", instr_data, 32'hFF0000A5);
        chk("stall_i2", instr_index, 2);
        @(negedge clk);
        chk("stall_done", done, 1);
        chk("stall_disc", exp_mu_discovery, 1);
        chk("stall_exec", exp_mu_execution, 2);

        // reset while word 1 is pending abandons it
        @(negedge clk);
        seed = 32'd0;
        length = 8'd2;
        start = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("pend_w1", instr_data, 32'h0A0020A5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_disc", exp_mu_discovery, 0);
        chk("mid_rst_exec", exp_mu_execution, 0);
        chk("mid_rst_mods", exp_num_modules, 0);
        run(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
